// File: rtl/shift_in_receiver_pkg.sv
// Shared constants and state encoding for the MSB-first serial word receiver.
// Word width is derived from the datapath nibble width used across the slice.
package shift_in_receiver_pkg;

   localparam int DATA_WIDTH = 4;
   localparam int WORD_WIDTH = DATA_WIDTH * 2;
   localparam int CNT_WIDTH  = $clog2(WORD_WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_t;

endpackage

// File: rtl/shift_in_receiver_if.sv
// Serial-link inputs, parallel word handshake and status for the receiver.
// The slave modport is the receiver's view; master is the link/consumer side.
interface shift_in_receiver_if
   import shift_in_receiver_pkg::*;
#(
   parameter int WORD_WIDTH = shift_in_receiver_pkg::WORD_WIDTH,
   parameter int CNT_WIDTH  = $clog2(WORD_WIDTH)
);
   logic                  bit_valid;
   logic                  bit_in;
   logic                  sync_in;
   logic                  word_ready;
   logic                  clear_err;
   logic [WORD_WIDTH-1:0] q_out;
   logic                  word_valid;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  bit_cnt;
   logic                  overrun_err;
   logic                  sync_err;

   modport slave (
      input  bit_valid, bit_in, sync_in, word_ready, clear_err,
      output q_out, word_valid, busy, bit_cnt, overrun_err, sync_err
   );

   modport master (
      output bit_valid, bit_in, sync_in, word_ready, clear_err,
      input  q_out, word_valid, busy, bit_cnt, overrun_err, sync_err
   );
endinterface

// File: rtl/shift_in_receiver_rx_output_holder.sv
// Holds the last completed word under a valid/ready handshake.
// Flags an overrun when a new word lands on one the consumer has not taken.
module rx_output_holder #(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [WORD_WIDTH-1:0] word,
   input  logic                  word_ready,
   output logic [WORD_WIDTH-1:0] q_out,
   output logic                  word_valid,
   output logic                  overrun_evt
);

   // A ready in the same cycle as a load retires the old word, so no overrun.
   assign overrun_evt = load & word_valid & ~word_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_out      <= '0;
         word_valid <= 1'b0;
      end else if (load) begin
         q_out      <= word;
         word_valid <= 1'b1;
      end else if (word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_in_receiver.sv
// Serial-in/parallel-out receiver: rebuilds MSB-first words framed by sync_in.
// state | meaning
// IDLE  | no word in progress; waits for a valid bit with sync_in
// SHIFT | word partially received; bit_cnt bits captured so far
module shift_in_receiver
   import shift_in_receiver_pkg::*;
#(
   parameter int WORD_WIDTH = shift_in_receiver_pkg::WORD_WIDTH,
   parameter int CNT_WIDTH  = $clog2(WORD_WIDTH)
) (
   input logic                clk,
   input logic                reset_n,
   shift_in_receiver_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(WORD_WIDTH - 1);

   rx_state_t             state, state_nxt;
   logic [WORD_WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_nxt;
   logic [WORD_WIDTH-1:0] shift_word;
   logic                  complete;
   logic                  resync;
   logic                  overrun_evt;
   logic                  overrun_q;
   logic                  sync_err_q;

   assign shift_word = {shreg[WORD_WIDTH-2:0], bus.bit_in};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt_q <= '0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         bit_cnt_q <= bit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt_q;
      complete    = 1'b0;
      resync      = 1'b0;
      if (bus.bit_valid) begin
         case (state)
            IDLE: begin
               if (bus.sync_in) begin
                  shreg_nxt   = WORD_WIDTH'(bus.bit_in);
                  bit_cnt_nxt = CNT_WIDTH'(1);
                  state_nxt   = SHIFT;
               end
            end
            SHIFT: begin
               // The completing bit wins over a coincident sync_in.
               if (bit_cnt_q == LAST_BIT) begin
                  complete    = 1'b1;
                  shreg_nxt   = shift_word;
                  bit_cnt_nxt = '0;
                  state_nxt   = IDLE;
               end else if (bus.sync_in) begin
                  resync      = 1'b1;
                  shreg_nxt   = WORD_WIDTH'(bus.bit_in);
                  bit_cnt_nxt = CNT_WIDTH'(1);
               end else begin
                  shreg_nxt   = shift_word;
                  bit_cnt_nxt = bit_cnt_q + CNT_WIDTH'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   rx_output_holder #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_holder (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (complete),
      .word        (shift_word),
      .word_ready  (bus.word_ready),
      .q_out       (bus.q_out),
      .word_valid  (bus.word_valid),
      .overrun_evt (overrun_evt)
   );

   // Sticky flags: a new event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q  <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         if (overrun_evt)        overrun_q <= 1'b1;
         else if (bus.clear_err) overrun_q <= 1'b0;
         if (resync)             sync_err_q <= 1'b1;
         else if (bus.clear_err) sync_err_q <= 1'b0;
      end
   end

   assign bus.busy        = (state == SHIFT);
   assign bus.bit_cnt     = bit_cnt_q;
   assign bus.overrun_err = overrun_q;
   assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_shift_in_receiver.sv
// Directed and randomized bench for shift_in_receiver against a word-level model.
module tb_shift_in_receiver;
   import shift_in_receiver_pkg::*;

   localparam int W = shift_in_receiver_pkg::WORD_WIDTH;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   shift_in_receiver_if bus ();

   shift_in_receiver dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model: word framing tracked as a bit count plus accumulated value.
   bit           m_in_word;
   int           m_cnt;
   int unsigned  m_acc;
   logic [W-1:0] m_q;
   bit           m_valid, m_oerr, m_serr;

   task automatic model_reset();
      m_in_word = 0; m_cnt = 0; m_acc = 0;
      m_q = '0; m_valid = 0; m_oerr = 0; m_serr = 0;
   endtask

   task automatic model_step(bit v, bit b, bit s, bit r, bit c);
      bit done = 0, oevt = 0, sevt = 0;
      int unsigned word = 0;
      if (v) begin
         if (m_in_word && m_cnt == W - 1) begin
            word = (m_acc * 2 + b) % (1 << W);
            done = 1; m_in_word = 0; m_cnt = 0; m_acc = 0;
         end else if (s) begin
            sevt = m_in_word;
            m_in_word = 1; m_cnt = 1; m_acc = b;
         end else if (m_in_word) begin
            m_acc = m_acc * 2 + b; m_cnt++;
         end
      end
      if (done) begin
         oevt = m_valid && !r;
         m_q = W'(word); m_valid = 1;
      end else if (r) begin
         m_valid = 0;
      end
      if (oevt) m_oerr = 1; else if (c) m_oerr = 0;
      if (sevt) m_serr = 1; else if (c) m_serr = 0;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".q_out"},       32'(bus.q_out),      32'(m_q));
      chk({tag, ".word_valid"},  32'(bus.word_valid), 32'(m_valid));
      chk({tag, ".busy"},        32'(bus.busy),       32'(m_in_word));
      chk({tag, ".bit_cnt"},     32'(bus.bit_cnt),    32'(m_cnt));
      chk({tag, ".overrun_err"}, 32'(bus.overrun_err), 32'(m_oerr));
      chk({tag, ".sync_err"},    32'(bus.sync_err),   32'(m_serr));
   endtask

   // One clock: drive inputs, model the edge, sample 1 time unit after it.
   task automatic step(string tag, bit v, bit b, bit s, bit r, bit c);
      bus.bit_valid = v; bus.bit_in = b; bus.sync_in = s;
      bus.word_ready = r; bus.clear_err = c;
      @(posedge clk);
      model_step(v, b, s, r, c);
      #1;
      check_all(tag);
   endtask

   task automatic send_bits(string tag, logic [W-1:0] word, int first, int last,
                            bit sync_first, bit ready_last);
      for (int i = first; i <= last; i++)
         step(tag, 1'b1, word[W-1-i], sync_first && i == first,
              ready_last && i == W - 1, 1'b0);
   endtask

   initial begin
      bus.bit_valid = 0; bus.bit_in = 0; bus.sync_in = 0;
      bus.word_ready = 0; bus.clear_err = 0;
      model_reset();
      #12;
      check_all("reset");
      reset_n = 1'b1;
      #5;

      send_bits("a5", 8'hA5, 0, W - 1, 1, 0);
      chk("a5_q", 32'(bus.q_out), 32'hA5);
      chk("a5_valid", 32'(bus.word_valid), 32'h1);
      chk("a5_cnt", 32'(bus.bit_cnt), 32'h0);
      chk("a5_busy", 32'(bus.busy), 32'h0);
      step("accept", 0, 0, 0, 1, 0);
      chk("accept_valid", 32'(bus.word_valid), 32'h0);
      chk("accept_hold_q", 32'(bus.q_out), 32'hA5);

      send_bits("3c", 8'h3C, 0, 3, 1, 0);
      repeat (3) step("gap", 0, 1, 1, 0, 0);
      chk("gap_cnt", 32'(bus.bit_cnt), 32'h4);
      send_bits("3c", 8'h3C, 4, W - 1, 0, 0);
      chk("3c_q", 32'(bus.q_out), 32'h3C);
      step("accept", 0, 0, 0, 1, 0);

      send_bits("f0", 8'hF0, 0, W - 1, 1, 0);
      send_bits("0f", 8'h0F, 0, W - 1, 1, 0);
      chk("ovr_q", 32'(bus.q_out), 32'h0F);
      chk("ovr_valid", 32'(bus.word_valid), 32'h1);
      chk("ovr_err", 32'(bus.overrun_err), 32'h1);
      step("clr", 0, 0, 0, 1, 1);
      chk("clr_ovr", 32'(bus.overrun_err), 32'h0);

      send_bits("f0b", 8'hF0, 0, W - 1, 1, 0);
      send_bits("0fb", 8'h0F, 0, W - 1, 1, 1);
      chk("noovr_err", 32'(bus.overrun_err), 32'h0);
      chk("noovr_valid", 32'(bus.word_valid), 32'h1);
      chk("noovr_q", 32'(bus.q_out), 32'h0F);
      step("accept", 0, 0, 0, 1, 0);

      send_bits("part", 8'hFF, 0, 4, 1, 0);
      send_bits("81", 8'h81, 0, W - 1, 1, 0);
      chk("resync_err", 32'(bus.sync_err), 32'h1);
      chk("resync_q", 32'(bus.q_out), 32'h81);
      step("clr_sync", 0, 0, 0, 1, 1);
      chk("clr_sync_err", 32'(bus.sync_err), 32'h0);

      // Sync on the completing bit must be ignored.
      send_bits("cs", 8'h6B, 0, W - 2, 1, 0);
      step("cs_last", 1, 1, 1, 0, 0);
      chk("cs_q", 32'(bus.q_out), 32'h6B);
      chk("cs_serr", 32'(bus.sync_err), 32'h0);
      chk("cs_busy", 32'(bus.busy), 32'h0);
      step("accept", 0, 0, 0, 1, 0);

      send_bits("mid", 8'hC3, 0, 5, 1, 0);
      chk("mid_cnt", 32'(bus.bit_cnt), 32'h6);
      #3 reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_cnt", 32'(bus.bit_cnt), 32'h0);
      #2 reset_n = 1'b1;
      #4;
      send_bits("5a", 8'h5A, 0, W - 1, 1, 0);
      chk("5a_q", 32'(bus.q_out), 32'h5A);
      step("accept", 0, 0, 0, 1, 0);

      repeat (3) step("nosync", 1, 1, 0, 0, 0);
      chk("nosync_cnt", 32'(bus.bit_cnt), 32'h0);
      chk("nosync_busy", 32'(bus.busy), 32'h0);
      chk("nosync_valid", 32'(bus.word_valid), 32'h0);

      for (int n = 0; n < 600; n++)
         step("rand", $urandom_range(3) != 0, 1'($urandom), $urandom_range(5) == 0,
              $urandom_range(2) == 0, $urandom_range(19) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
